// File: rtl/div_seq_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One operation in flight; valid/ready on both sides; flush kills any pending work.
module div_seq_unit #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       in_op,
   input  logic [XLEN-1:0]  in_a,
   input  logic [XLEN-1:0]  in_b,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_result,
   output logic [TAG_W-1:0] out_tag,
   output logic [1:0]       dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high (and flush is low); valid holds its payload stable until then.

   localparam int CNT_W = $clog2(XLEN + 1);
   localparam logic [4:0] OP_DIV  = 5'b10111;
   localparam logic [4:0] OP_DIVU = 5'b11000;
   localparam logic [4:0] OP_REM  = 5'b11001;
   localparam logic [4:0] OP_REMU = 5'b11010;
   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [XLEN-1:0]   quot_q, quot_d;
   logic [XLEN-1:0]   rem_q, rem_d;
   logic [XLEN-1:0]   div_q, div_d;
   logic [XLEN-1:0]   res_q, res_d;
   logic [TAG_W-1:0]  tag_q, tag_d;
   logic              neg_quot_q, neg_quot_d;
   logic              neg_rem_q, neg_rem_d;
   logic              rem_sel_q, rem_sel_d;
   logic              special_q, special_d;

   logic              is_supported, is_signed, is_rem, a_neg, b_neg;
   logic [XLEN-1:0]   abs_a, abs_b;
   logic [XLEN:0]     shifted, diff;
   logic [XLEN-1:0]   quot_step, rem_step;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         quot_q     <= '0;
         rem_q      <= '0;
         div_q      <= '0;
         res_q      <= '0;
         tag_q      <= '0;
         neg_quot_q <= 1'b0;
         neg_rem_q  <= 1'b0;
         rem_sel_q  <= 1'b0;
         special_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         quot_q     <= quot_d;
         rem_q      <= rem_d;
         div_q      <= div_d;
         res_q      <= res_d;
         tag_q      <= tag_d;
         neg_quot_q <= neg_quot_d;
         neg_rem_q  <= neg_rem_d;
         rem_sel_q  <= rem_sel_d;
         special_q  <= special_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      quot_d     = quot_q;
      rem_d      = rem_q;
      div_d      = div_q;
      res_d      = res_q;
      tag_d      = tag_q;
      neg_quot_d = neg_quot_q;
      neg_rem_d  = neg_rem_q;
      rem_sel_d  = rem_sel_q;
      special_d  = special_q;

      is_supported = (in_op == OP_DIV) || (in_op == OP_DIVU) ||
                     (in_op == OP_REM) || (in_op == OP_REMU);
      is_signed    = (in_op == OP_DIV) || (in_op == OP_REM);
      is_rem       = (in_op == OP_REM) || (in_op == OP_REMU);
      a_neg        = is_signed & in_a[XLEN-1];
      b_neg        = is_signed & in_b[XLEN-1];
      abs_a        = a_neg ? -in_a : in_a;
      abs_b        = b_neg ? -in_b : in_b;

      // quot_q doubles as the dividend shift register: its MSB feeds the partial remainder.
      shifted = {rem_q, quot_q[XLEN-1]};
      diff    = shifted - {1'b0, div_q};
      if (!diff[XLEN]) begin
         rem_step  = diff[XLEN-1:0];
         quot_step = {quot_q[XLEN-2:0], 1'b1};
      end else begin
         rem_step  = shifted[XLEN-1:0];
         quot_step = {quot_q[XLEN-2:0], 1'b0};
      end

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               state_d    = S_BUSY;
               tag_d      = in_tag;
               cnt_d      = '0;
               rem_d      = '0;
               div_d      = abs_b;
               quot_d     = abs_a;
               neg_quot_d = a_neg ^ b_neg;
               neg_rem_d  = a_neg;
               rem_sel_d  = is_rem;
               special_d  = 1'b1;
               // Special outcomes are parked in quot_q and released on the next edge.
               if (!is_supported) begin
                  quot_d = '0;
               end else if (in_b == '0) begin
                  quot_d = is_rem ? in_a : '1;
               end else if (is_signed && (in_a == INT_MIN) && (in_b == '1)) begin
                  quot_d = is_rem ? '0 : INT_MIN;
               end else begin
                  special_d = 1'b0;
               end
            end
         end
         S_BUSY: begin
            if (special_q) begin
               res_d   = quot_q;
               state_d = S_DONE;
            end else if (cnt_q == CNT_W'(XLEN)) begin
               res_d   = rem_sel_q ? (neg_rem_q ? -rem_q : rem_q)
                                   : (neg_quot_q ? -quot_q : quot_q);
               state_d = S_DONE;
            end else begin
               quot_d = quot_step;
               rem_d  = rem_step;
               cnt_d  = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (flush) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end
   end

   assign in_ready   = (state_q == S_IDLE);
   assign out_valid  = (state_q == S_DONE);
   assign out_result = res_q;
   assign out_tag    = tag_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_div_seq_unit.sv
// Directed and randomized checks of div_seq_unit against an arithmetic reference model.
module tb_div_seq_unit;

   localparam int XLEN  = 32;
   localparam int TAG_W = 6;
   localparam logic [4:0] OP_DIV  = 5'b10111;
   localparam logic [4:0] OP_DIVU = 5'b11000;
   localparam logic [4:0] OP_REM  = 5'b11001;
   localparam logic [4:0] OP_REMU = 5'b11010;
   localparam logic [4:0] OP_BAD  = 5'b00011;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [4:0]       in_op;
   logic [XLEN-1:0]  in_a;
   logic [XLEN-1:0]  in_b;
   logic [TAG_W-1:0] in_tag;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_result;
   logic [TAG_W-1:0] out_tag;
   logic [1:0]       dbg_state;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   div_seq_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_tag     (in_tag),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_tag    (out_tag),
      .dbg_state  (dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   // Reference results straight from the RV32M rules, using wide signed arithmetic.
   function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         OP_REMU: return (b == 0) ? a : a % b;
         OP_DIV:  return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
         OP_REM:  return (b == 0) ? a : 32'(sa % sb);
         default: return 32'h0;
      endcase
   endfunction

   function automatic int exp_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      bit signed_op = (op == OP_DIV) || (op == OP_REM);
      if (!(signed_op || op == OP_DIVU || op == OP_REMU)) return 1;
      if (b == 0) return 1;
      if (signed_op && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return XLEN + 1;
   endfunction

   // Starts #1 after a rising edge with the unit idle; returns after the output handshake.
   task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] tag, output logic [31:0] res,
                         output logic [TAG_W-1:0] rtag, output int lat);
      in_valid  = 1'b1;
      in_op     = op;
      in_a      = a;
      in_b      = b;
      in_tag    = tag;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!out_valid && lat < 100);
      res  = out_result;
      rtag = out_tag;
      if (out_valid) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_check(input string name, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [TAG_W-1:0] tag);
      logic [31:0]      res;
      logic [TAG_W-1:0] rtag;
      int               lat;
      check({name, "_ready"}, 32'(in_ready), 32'd1);
      run_op(op, a, b, tag, res, rtag, lat);
      check({name, "_res"}, res, model(op, a, b));
      check({name, "_tag"}, 32'(rtag), 32'(tag));
      check({name, "_lat"}, 32'(lat), 32'(exp_lat(op, a, b)));
      check({name, "_drop"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      logic [31:0]      held_res;
      logic [TAG_W-1:0] held_tag;
      logic [4:0]       r_op;
      logic [31:0]      r_a, r_b;
      int               lat;
      bit               seen;
      logic [4:0]       op_tab [5];
      op_tab[0] = OP_DIV;
      op_tab[1] = OP_DIVU;
      op_tab[2] = OP_REM;
      op_tab[3] = OP_REMU;
      op_tab[4] = OP_BAD;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_op     = '0;
      in_a      = '0;
      in_b      = '0;
      in_tag    = '0;
      flush     = 1'b0;
      out_ready = 1'b1;
      #23;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_result", out_result, 32'd0);
      check("rst_out_tag", 32'(out_tag), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      do_check("div_100_7", OP_DIV, 32'd100, 32'd7, 6'd5);
      check("div_100_7_const", model(OP_DIV, 32'd100, 32'd7), 32'd14);
      do_check("rem_100_7", OP_REM, 32'd100, 32'd7, 6'd6);
      do_check("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 6'd10);
      do_check("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 6'd11);
      do_check("divu_m7_2", OP_DIVU, 32'hFFFF_FFF9, 32'd2, 6'd12);
      do_check("divu_by0", OP_DIVU, 32'h0000_1234, 32'd0, 6'd13);
      do_check("remu_by0", OP_REMU, 32'h0000_1234, 32'd0, 6'd14);
      do_check("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 6'd15);
      do_check("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 6'd16);
      do_check("unsupported", OP_BAD, 32'd55, 32'd5, 6'd17);
      do_check("div_by_neg", OP_DIV, 32'd100, 32'hFFFF_FFF9, 6'd18);

      // Backpressure: result must sit still while a second request waits.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_op     = OP_DIVU;
      in_a      = 32'd1000;
      in_b      = 32'd10;
      in_tag    = 6'd7;
      @(posedge clk);
      #1;
      in_op  = OP_DIVU;
      in_a   = 32'd500;
      in_b   = 32'd4;
      in_tag = 6'd9;
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!out_valid && lat < 100);
      check("bp_lat", 32'(lat), 32'd33);
      check("bp_res", out_result, 32'd100);
      check("bp_tag", 32'(out_tag), 32'd7);
      held_res = out_result;
      held_tag = out_tag;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check("bp_hold_valid", 32'(out_valid), 32'd1);
         check("bp_hold_res", out_result, held_res);
         check("bp_hold_tag", 32'(out_tag), 32'(held_tag));
         check("bp_hold_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_handshake_valid", 32'(out_valid), 32'd0);
      check("bp_handshake_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("bp_second_accepted", 32'(in_ready), 32'd0);
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!out_valid && lat < 100);
      check("bp2_lat", 32'(lat), 32'd33);
      check("bp2_res", out_result, 32'd125);
      check("bp2_tag", 32'(out_tag), 32'd9);
      @(posedge clk);
      #1;

      // Flush during iteration 15.
      in_valid = 1'b1;
      in_op    = OP_DIV;
      in_a     = 32'd12345;
      in_b     = 32'd17;
      in_tag   = 6'd3;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      check("flush_pre_busy", 32'(in_ready), 32'd0);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("flush_idle_ready", 32'(in_ready), 32'd1);
      check("flush_no_valid", 32'(out_valid), 32'd0);
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (out_valid) seen = 1'b1;
      end
      check("flush_never_valid", 32'(seen), 32'd0);
      do_check("post_flush_divu", OP_DIVU, 32'd9, 32'd3, 6'd42);

      // Flush in IDLE blocks a simultaneous request.
      in_valid = 1'b1;
      in_op    = OP_DIVU;
      in_a     = 32'd8;
      in_b     = 32'd2;
      flush    = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      flush    = 1'b0;
      check("flush_idle_reject", 32'(in_ready), 32'd1);

      // Flush in DONE with out_ready high discards the result.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_op     = OP_DIVU;
      in_a      = 32'd0;
      in_b      = 32'd0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("done_before_flush", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      flush     = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("done_flush_valid", 32'(out_valid), 32'd0);
      check("done_flush_ready", 32'(in_ready), 32'd1);

      // Asynchronous reset mid-operation.
      in_valid = 1'b1;
      in_op    = OP_DIV;
      in_a     = 32'd777;
      in_b     = 32'd5;
      in_tag   = 6'd21;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("areset_valid", 32'(out_valid), 32'd0);
      check("areset_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (out_valid) seen = 1'b1;
      end
      check("areset_no_stale", 32'(seen), 32'd0);
      check("areset_ready_after", 32'(in_ready), 32'd1);
      do_check("post_reset_rem", OP_REM, 32'hFFFF_FF00, 32'd7, 6'd33);

      for (int i = 0; i < 40; i++) begin
         r_op = op_tab[$urandom_range(0, 4)];
         r_a  = $urandom;
         case ($urandom_range(0, 5))
            0:       r_b = 32'd0;
            1:       r_b = 32'($urandom_range(1, 15));
            2:       r_b = 32'hFFFF_FFFF;
            default: r_b = $urandom;
         endcase
         if ($urandom_range(0, 9) == 0) r_a = 32'h8000_0000;
         do_check("rand", r_op, r_a, r_b, 6'($urandom_range(0, 63)));
      end

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
